// File: rtl/crossbar_2x2_scheduler.sv
// rtl/crossbar_2x2_scheduler.sv - 2x2 crossbar front end: input FIFOs, round-robin conflict arbiter, registered outputs
module crossbar_2x2_scheduler #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_dest,
    output logic             in1_ready,
    input  logic             in2_valid,
    input  logic [WIDTH-1:0] in2_data,
    input  logic             in2_dest,
    output logic             in2_ready,
    output logic             out1_valid,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_src,
    input  logic             out1_ready,
    output logic             out2_valid,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_src,
    input  logic             out2_ready,
    output logic             control,
    output logic [CNT_W-1:0] conflicts
);
    localparam int EW = WIDTH + 1;

    logic [EW-1:0]    r_mem [2][2];
    logic [1:0]       r_rd;
    logic [1:0]       r_cnt [2];
    logic [1:0]       r_ov;
    logic [WIDTH-1:0] r_od  [2];
    logic [1:0]       r_os;
    logic             r_ctrl;
    logic             r_prio;
    logic [CNT_W-1:0] r_conf;

    logic [EW-1:0]    w_in_pkt [2];
    logic [EW-1:0]    w_head   [2];
    logic [1:0]       w_in_valid, w_oready, w_hv, w_hd, w_acc, w_push, w_mv;
    logic [1:0]       w_ld, w_lsrc;
    logic             w_conf, w_res;

    assign w_in_pkt[0] = {in1_dest, in1_data};
    assign w_in_pkt[1] = {in2_dest, in2_data};
    assign w_in_valid  = {in2_valid, in1_valid};
    assign w_oready    = {out2_ready, out1_ready};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_head[i] = r_mem[i][r_rd[i]];
            w_hv[i]   = (r_cnt[i] != 2'd0);
            w_hd[i]   = w_head[i][WIDTH];
            w_push[i] = w_in_valid[i] & (r_cnt[i] != 2'd2);
            w_acc[i]  = ~r_ov[i] | w_oready[i];
        end
        // On a same-destination clash only the prio-selected head may move
        w_conf  = (&w_hv) & (w_hd[0] == w_hd[1]);
        w_mv[0] = w_hv[0] & w_acc[w_hd[0]] & (~w_conf | ~r_prio);
        w_mv[1] = w_hv[1] & w_acc[w_hd[1]] & (~w_conf | r_prio);
        w_res   = w_conf & w_acc[w_hd[0]];
        w_lsrc[0] = w_mv[1] & ~w_hd[1];
        w_lsrc[1] = w_mv[1] & w_hd[1];
        w_ld[0]   = (w_mv[0] & ~w_hd[0]) | w_lsrc[0];
        w_ld[1]   = (w_mv[0] & w_hd[0]) | w_lsrc[1];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (w_push[i])
                r_mem[i][r_rd[i] ^ r_cnt[i][0]] <= w_in_pkt[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd   <= '0;
            r_cnt  <= '{2'd0, 2'd0};
            r_ov   <= '0;
            r_od   <= '{'0, '0};
            r_os   <= '0;
            r_ctrl <= 1'b0;
            r_prio <= 1'b0;
            r_conf <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_mv[i])
                    r_rd[i] <= ~r_rd[i];
                r_cnt[i] <= r_cnt[i] + {1'b0, w_push[i]} - {1'b0, w_mv[i]};
            end
            for (int k = 0; k < 2; k++) begin
                if (w_ld[k]) begin
                    r_ov[k] <= 1'b1;
                    r_od[k] <= w_lsrc[k] ? w_head[1][WIDTH-1:0] : w_head[0][WIDTH-1:0];
                    r_os[k] <= w_lsrc[k];
                end else if (w_oready[k]) begin
                    r_ov[k] <= 1'b0;
                end
            end
            if (|w_mv)
                r_ctrl <= (w_mv[0] & w_hd[0]) | (w_mv[1] & ~w_hd[1]);
            if (w_res) begin
                r_prio <= ~r_prio;
                if (r_conf != {CNT_W{1'b1}})
                    r_conf <= r_conf + 1'b1;
            end
        end
    end

    assign in1_ready  = (r_cnt[0] != 2'd2);
    assign in2_ready  = (r_cnt[1] != 2'd2);
    assign out1_valid = r_ov[0];
    assign out1_data  = r_od[0];
    assign out1_src   = r_os[0];
    assign out2_valid = r_ov[1];
    assign out2_data  = r_od[1];
    assign out2_src   = r_os[1];
    assign control    = r_ctrl;
    assign conflicts  = r_conf;
endmodule

// File: tb/tb_crossbar_2x2_scheduler.sv
// tb/tb_crossbar_2x2_scheduler.sv - randomized and directed check of crossbar_2x2_scheduler against a queue model
module tb_crossbar_2x2_scheduler;
    typedef logic [4:0] pkt_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in1_valid = 1'b0, in2_valid = 1'b0;
    logic [3:0] in1_data = '0, in2_data = '0;
    logic       in1_dest = 1'b0, in2_dest = 1'b0;
    logic       in1_ready, in2_ready;
    logic       out1_valid, out2_valid;
    logic [3:0] out1_data, out2_data;
    logic       out1_src, out2_src;
    logic       out1_ready = 1'b1, out2_ready = 1'b1;
    logic       control;
    logic [7:0] conflicts;

    crossbar_2x2_scheduler #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_dest(in1_dest), .in1_ready(in1_ready),
        .in2_valid(in2_valid), .in2_data(in2_data), .in2_dest(in2_dest), .in2_ready(in2_ready),
        .out1_valid(out1_valid), .out1_data(out1_data), .out1_src(out1_src), .out1_ready(out1_ready),
        .out2_valid(out2_valid), .out2_data(out2_data), .out2_src(out2_src), .out2_ready(out2_ready),
        .control(control), .conflicts(conflicts)
    );

    always #5 clk = ~clk;

    int         chk_cnt = 0;
    int         pass_cnt = 0;
    pkt_t       q0[$];
    pkt_t       q1[$];
    logic       m_ov [2];
    logic [3:0] m_od [2];
    logic       m_os [2];
    logic       m_ctrl, m_prio;
    int         m_conf;
    logic [3:0] dut_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("o1_valid", out1_valid, m_ov[0]);
        if (m_ov[0]) begin
            chk("o1_data", out1_data, m_od[0]);
            chk("o1_src", out1_src, m_os[0]);
        end
        chk("o2_valid", out2_valid, m_ov[1]);
        if (m_ov[1]) begin
            chk("o2_data", out2_data, m_od[1]);
            chk("o2_src", out2_src, m_os[1]);
        end
        chk("control", control, m_ctrl);
        chk("conflicts", conflicts, m_conf);
        chk("in1_ready", in1_ready, q0.size() < 2);
        chk("in2_ready", in2_ready, q1.size() < 2);
    endtask

    task automatic model_clear();
        q0.delete(); q1.delete(); dut_log.delete();
        m_ov = '{1'b0, 1'b0}; m_od = '{4'h0, 4'h0}; m_os = '{1'b0, 1'b0};
        m_ctrl = 1'b0; m_prio = 1'b0; m_conf = 0;
    endtask

    // One clock: apply the arbitration rules to the queues, advance, then compare
    task automatic tick();
        pkt_t h0, h1;
        bit   hv0, hv1, mv0, mv1, p0, p1, want0, want1;
        bit   acc [2];
        hv0 = q0.size() > 0; h0 = hv0 ? q0[0] : '0;
        hv1 = q1.size() > 0; h1 = hv1 ? q1[0] : '0;
        p0 = in1_valid && q0.size() < 2;
        p1 = in2_valid && q1.size() < 2;
        acc[0] = !m_ov[0] || out1_ready;
        acc[1] = !m_ov[1] || out2_ready;
        if (out1_valid && out1_ready) dut_log.push_back(out1_data);
        mv0 = 0; mv1 = 0;
        for (int k = 0; k < 2; k++) begin
            want0 = hv0 && (int'(h0[4]) == k);
            want1 = hv1 && (int'(h1[4]) == k);
            if (acc[k]) begin
                if (want0 && want1) begin
                    if (m_prio == 1'b0) mv0 = 1; else mv1 = 1;
                    m_prio = !m_prio;
                    if (m_conf < 255) m_conf++;
                end else begin
                    if (want0) mv0 = 1;
                    if (want1) mv1 = 1;
                end
            end
        end
        if (m_ov[0] && out1_ready) m_ov[0] = 1'b0;
        if (m_ov[1] && out2_ready) m_ov[1] = 1'b0;
        if (mv0) begin
            m_ov[h0[4]] = 1'b1; m_od[h0[4]] = h0[3:0]; m_os[h0[4]] = 1'b0;
            void'(q0.pop_front());
        end
        if (mv1) begin
            m_ov[h1[4]] = 1'b1; m_od[h1[4]] = h1[3:0]; m_os[h1[4]] = 1'b1;
            void'(q1.pop_front());
        end
        if (mv0 || mv1) m_ctrl = (mv0 && h0[4]) || (mv1 && !h1[4]);
        if (p0) q0.push_back({in1_dest, in1_data});
        if (p1) q1.push_back({in2_dest, in2_data});
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Called at posedge+1: raises rst mid-cycle, checks, releases just after the next edge
    task automatic do_reset();
        #3;
        rst = 1'b1;
        in1_valid = 1'b0; in2_valid = 1'b0;
        #1;
        model_clear();
        chk("rst_o1_valid", out1_valid, 0);
        chk("rst_o2_valid", out2_valid, 0);
        chk("rst_o1_data", out1_data, 0);
        chk("rst_o2_data", out2_data, 0);
        chk("rst_srcs", {out1_src, out2_src}, 0);
        chk("rst_control", control, 0);
        chk("rst_conflicts", conflicts, 0);
        chk("rst_readys", {in1_ready, in2_ready}, 2'b11);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic stream(input int n0, input int n1, input logic [3:0] b0, input logic [3:0] b1,
                          input logic d0, input logic d1);
        int i0 = 0, i1 = 0;
        bit a0, a1;
        for (int cyc = 0; cyc < 40 && (i0 < n0 || i1 < n1); cyc++) begin
            in1_valid = i0 < n0; in1_data = b0 + 4'(i0); in1_dest = d0;
            in2_valid = i1 < n1; in2_data = b1 + 4'(i1); in2_dest = d1;
            a0 = in1_valid && q0.size() < 2;
            a1 = in2_valid && q1.size() < 2;
            tick();
            if (a0) i0++;
            if (a1) i1++;
        end
        in1_valid = 1'b0; in2_valid = 1'b0;
        chk("stream_done", {i0[15:0], i1[15:0]}, {n0[15:0], n1[15:0]});
    endtask

    logic [3:0] rr_exp [8] = '{4'h0, 4'h8, 4'h1, 4'h9, 4'h2, 4'hA, 4'h3, 4'hB};

    initial begin
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        // Straight
        out1_ready = 1; out2_ready = 1;
        in1_valid = 1; in1_data = 4'h8; in1_dest = 0;
        in2_valid = 1; in2_data = 4'h1; in2_dest = 1;
        tick();
        in1_valid = 0; in2_valid = 0;
        tick();
        chk("straight_o1", {out1_valid, out1_src, out1_data}, {1'b1, 1'b0, 4'h8});
        chk("straight_o2", {out2_valid, out2_src, out2_data}, {1'b1, 1'b1, 4'h1});
        chk("straight_ctrl", control, 0);
        tick();

        // Cross
        in1_valid = 1; in1_data = 4'h3; in1_dest = 1;
        in2_valid = 1; in2_data = 4'hC; in2_dest = 0;
        tick();
        in1_valid = 0; in2_valid = 0;
        tick();
        chk("cross_o2", {out2_valid, out2_src, out2_data}, {1'b1, 1'b0, 4'h3});
        chk("cross_o1", {out1_valid, out1_src, out1_data}, {1'b1, 1'b1, 4'hC});
        chk("cross_ctrl", control, 1);
        tick();

        // Conflict round-robin
        do_reset();
        stream(4, 4, 4'h0, 4'h8, 1'b0, 1'b0);
        for (int c = 0; c < 20 && dut_log.size() < 8; c++) tick();
        chk("rr_count", dut_log.size(), 8);
        for (int i = 0; i < 8 && i < dut_log.size(); i++) chk("rr_seq", dut_log[i], rr_exp[i]);
        chk("rr_conflicts", conflicts, 7);

        // Backpressure
        do_reset();
        out1_ready = 0;
        stream(3, 0, 4'h1, 4'h0, 1'b0, 1'b0);
        tick(); tick();
        chk("bp_hold", {out1_valid, out1_data}, {1'b1, 4'h1});
        chk("bp_in1_ready", in1_ready, 0);
        out1_ready = 1;
        for (int c = 0; c < 20 && dut_log.size() < 3; c++) tick();
        chk("bp_count", dut_log.size(), 3);
        for (int i = 0; i < 3 && i < dut_log.size(); i++) chk("bp_seq", dut_log[i], 4'(i + 1));
        chk("bp_in1_ready_back", in1_ready, 1);

        // Reset mid-operation with full FIFOs and valid outputs
        out1_ready = 0; out2_ready = 0;
        stream(3, 3, 4'h2, 4'h6, 1'b0, 1'b1);
        chk("mid_full", {out1_valid, out2_valid, in1_ready, in2_ready}, 4'b1100);
        do_reset();
        out1_ready = 1; out2_ready = 1;
        for (int c = 0; c < 5; c++) tick();
        in1_valid = 1; in1_data = 4'h5; in1_dest = 1;
        tick();
        in1_valid = 0;
        chk("lat_edge1", out2_valid, 0);
        tick();
        chk("lat_edge2", {out2_valid, out2_src, out2_data}, {1'b1, 1'b0, 4'h5});

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            in1_valid = $urandom_range(0, 9) < 7; in1_data = 4'($urandom); in1_dest = 1'($urandom);
            in2_valid = $urandom_range(0, 9) < 7; in2_data = 4'($urandom); in2_dest = 1'($urandom);
            out1_ready = $urandom_range(0, 3) != 0;
            out2_ready = $urandom_range(0, 3) != 0;
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
